shift_rows_pipe: RTL and testbench

Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. Supports Rijndael block widths of Nb = 4, 6 or 8 columns and a per-transfer direction select. Carries a sideband tag aligned with the data. Uses a valid/ready handshake so it can sit between SubBytes and MixColumns with arbitrary back-pressure.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/shift_rows_pipe_if.sv | 30 +++
 rtl/shift_rows_perm.sv | 26 ++
 rtl/shift_rows_pipe.sv | 74 +++++++
 tb/tb_shift_rows_pipe.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: Rijndael ShiftRows row offsets, block-width checks and
// the column/row to byte-index mapping used by the state permutation.
package aes_pkg;

    function automatic int state_w(input int nb);
        return 32 * nb;
    endfunction

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Wide Rijndael blocks skip offset 2: rows 2 and 3 shift by 3 and 4
    function automatic int shift_off(input int nb, input int r);
        return ((nb == 8) && (r >= 2)) ? r + 1 : r;
    endfunction

    function automatic int byte_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready streaming bus around the ShiftRows pipeline: upstream state
// entry with direction and tag, downstream permuted state with tag.
interface shift_rows_pipe_if
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    localparam int DW = state_w(NB);

    logic             in_valid;
    logic             in_ready;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic [DW-1:0]    in_state;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [DW-1:0]    out_state;

    modport master (
        output in_valid, in_inv, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_tag, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_tag, out_state
    );
endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for Nb = 4, 6 or 8.
// Pure wiring plus a 2:1 mux per byte, so it is reusable inside a round core.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state_in,
    input  logic             inv,
    output logic [32*NB-1:0] state_out
);
    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_perm: NB must be 4, 6 or 8");
    end

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = shift_off(NB, r);
            localparam int FWD = byte_idx((c + OFF) % NB, r);
            localparam int INV = byte_idx((c + NB - OFF) % NB, r);
            localparam int DST = byte_idx(c, r);
            assign state_out[8*DST +: 8] = inv ? state_in[8*INV +: 8]
                                               : state_in[8*FWD +: 8];
        end
    end
endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage with valid/ready flow control and
// a sideband tag; the permutation feeds stage 0, later stages are pure delay.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    shift_rows_pipe_if.slave  bus
);
    localparam int DW = state_w(NB);

    if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end

    logic [DW-1:0]     perm_state;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] load;
    logic [TAG_W-1:0]  tag_p  [STAGES];
    logic [DW-1:0]     data_p [STAGES];

    shift_rows_perm #(.NB(NB)) u_perm (
        .state_in  (bus.in_state),
        .inv       (bus.in_inv),
        .state_out (perm_state)
    );

    // A stage can load if downstream drains or any stage at or after it is empty
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            load[i] = bus.out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!vld_p[j]) load[i] = 1'b1;
            end
        end
    end

    assign bus.in_ready  = load[0] | flush;
    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.out_tag   = tag_p[STAGES-1];
    assign bus.out_state = data_p[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_p[i]  <= '0;
                data_p[i] <= '0;
            end
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            // stage 0: permuted input
            if (load[0]) begin
                vld_p[0]  <= bus.in_valid;
                tag_p[0]  <= bus.in_tag;
                data_p[0] <= perm_state;
            end
            // stages 1..STAGES-1: delay line
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    vld_p[i]  <= vld_p[i-1];
                    tag_p[i]  <= tag_p[i-1];
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: FIPS-197 vector, wide-block offsets,
// round trips, back-pressure, flush and asynchronous reset mid-stream.
module tb_shift_rows_pipe;
    logic clk;
    logic rst_n;
    logic flush;
    int   tests;
    int   fails;

    shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
    shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();
    shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b2 ();

    shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b4));
    shift_rows_pipe #(.NB(8), .STAGES(3), .TAG_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b8));
    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference: rotate each row of a 4 x nb byte matrix
    function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input bit inv);
        logic [7:0]   m [4][8];
        logic [255:0] o;
        int           sh;
        int           src;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[8*(4*c+r) +: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r > 1) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c + nb - sh) % nb : (c + sh) % nb;
                o[8*(4*c+r) +: 8] = m[r][src];
            end
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [255:0] in8;
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] bp_in [1:7];
    logic [127:0] held_state;
    logic [3:0]   held_tag;
    bit           holding;
    int           next_tag;
    int           exp_tag;
    logic [11:0]  rdy_tbl;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        b4.in_valid = 0; b4.in_inv = 0; b4.in_tag = '0; b4.in_state = '0; b4.out_ready = 1;
        b8.in_valid = 0; b8.in_inv = 0; b8.in_tag = '0; b8.in_state = '0; b8.out_ready = 1;
        b2.in_valid = 0; b2.in_inv = 0; b2.in_tag = '0; b2.in_state = '0; b2.out_ready = 1;
        fips_in  = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;
        fips_out = 128'he5_98_27_1e_f1_11_41_b8_ae_52_b4_e0_30_5d_bf_d4;
        for (int k = 0; k < 32; k++) in8[8*k +: 8] = k[7:0];

        // reset state
        #12;
        check("rst_out_valid4", b4.out_valid, 0);
        check("rst_out_state4", b4.out_state, 0);
        check("rst_out_tag4", b4.out_tag, 0);
        check("rst_out_valid8", b8.out_valid, 0);
        check("rst_out_state8", b8.out_state, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready4", b4.in_ready, 1);
        check("post_rst_ready8", b8.in_ready, 1);
        check("post_rst_ready2", b2.in_ready, 1);

        // FIPS-197 forward then inverse, NB=4 STAGES=1
        b4.in_valid = 1; b4.in_inv = 0; b4.in_tag = 4'h5; b4.in_state = fips_in;
        tick();
        check("fips_fwd_valid", b4.out_valid, 1);
        check("fips_fwd_state", b4.out_state, fips_out);
        check("fips_fwd_tag", b4.out_tag, 4'h5);
        b4.in_inv = 1; b4.in_tag = 4'ha; b4.in_state = fips_out;
        tick();
        check("fips_inv_state", b4.out_state, fips_in);
        check("fips_inv_tag", b4.out_tag, 4'ha);
        b4.in_valid = 0;
        tick();
        check("fips_idle_valid", b4.out_valid, 0);

        // random back-to-back forward/inverse round trips
        b4.in_valid = 1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            b4.in_inv = 0; b4.in_state = x; b4.in_tag = i[3:0];
            tick();
            check("rt_fwd", b4.out_state, ref_shift({128'd0, x}, 4, 0));
            y = b4.out_state;
            b4.in_inv = 1; b4.in_state = y;
            tick();
            check("rt_identity", b4.out_state, x);
        end
        b4.in_valid = 0;
        tick();

        // NB=8 STAGES=3 offsets and latency
        b8.in_valid = 1; b8.in_inv = 0; b8.in_tag = 4'h3; b8.in_state = in8;
        tick();
        b8.in_valid = 0;
        check("nb8_lat1", b8.out_valid, 0);
        tick();
        check("nb8_lat2", b8.out_valid, 0);
        tick();
        check("nb8_lat3", b8.out_valid, 1);
        check("nb8_byte1", b8.out_state[15:8], 8'h05);
        check("nb8_byte2", b8.out_state[23:16], 8'h0e);
        check("nb8_byte3", b8.out_state[31:24], 8'h13);
        check("nb8_c5r3", b8.out_state[8*23 +: 8], 8'h07);
        check("nb8_state", b8.out_state, ref_shift(in8, 8, 0));
        check("nb8_tag", b8.out_tag, 4'h3);
        tick();
        check("nb8_drain", b8.out_valid, 0);

        // back-pressure, STAGES=2: out_ready low on cycles 3..5
        for (int t = 1; t <= 7; t++) bp_in[t] = {$urandom, $urandom, $urandom, $urandom};
        rdy_tbl  = 12'b1111_1110_0011;
        next_tag = 1;
        exp_tag  = 1;
        holding  = 0;
        b2.in_inv = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            b2.out_ready = !(cyc >= 3 && cyc <= 5);
            b2.in_valid  = (next_tag <= 6);
            b2.in_tag    = next_tag[3:0];
            b2.in_state  = bp_in[(next_tag <= 6) ? next_tag : 7];
            #1;
            check("bp_in_ready", b2.in_ready, rdy_tbl[cyc-1]);
            if (holding) begin
                check("bp_stable_valid", b2.out_valid, 1);
                check("bp_stable_state", b2.out_state, held_state);
                check("bp_stable_tag", b2.out_tag, held_tag);
            end
            if (b2.out_valid && b2.out_ready) begin
                check("bp_order_tag", b2.out_tag, exp_tag[3:0]);
                check("bp_data", b2.out_state, ref_shift({128'd0, bp_in[(exp_tag <= 6) ? exp_tag : 7]}, 4, 0));
                exp_tag++;
                holding = 0;
            end else if (b2.out_valid) begin
                holding    = 1;
                held_state = b2.out_state;
                held_tag   = b2.out_tag;
            end else begin
                holding = 0;
            end
            if (b2.in_valid && b2.in_ready) next_tag++;
            tick();
        end
        check("bp_emitted", exp_tag, 7);
        check("bp_accepted", next_tag, 7);
        b2.in_valid = 0; b2.out_ready = 1;

        // flush with two items in flight
        b2.in_valid = 1; b2.in_tag = 4'h7; b2.in_state = bp_in[1];
        tick();
        b2.in_tag = 4'h8; b2.in_state = bp_in[2];
        tick();
        check("fl_inflight_tag", b2.out_tag, 4'h7);
        b2.out_ready = 0; flush = 1; b2.in_tag = 4'h9; b2.in_state = bp_in[3];
        #1;
        check("fl_in_ready", b2.in_ready, 1);
        tick();
        flush = 0; b2.out_ready = 1;
        check("fl_cleared", b2.out_valid, 0);
        b2.in_tag = 4'ha; b2.in_state = bp_in[4]; b2.in_inv = 1;
        tick();
        b2.in_valid = 0;
        check("fl_lat1", b2.out_valid, 0);
        tick();
        check("fl_after_valid", b2.out_valid, 1);
        check("fl_after_tag", b2.out_tag, 4'ha);
        check("fl_after_state", b2.out_state, ref_shift({128'd0, bp_in[4]}, 4, 1));
        tick();
        check("fl_drain", b2.out_valid, 0);

        // asynchronous reset mid-stream
        b2.in_inv = 0;
        b2.in_valid = 1; b2.in_tag = 4'hb; b2.in_state = bp_in[5];
        tick();
        b2.in_tag = 4'hc; b2.in_state = bp_in[6];
        tick();
        check("ar_before_tag", b2.out_tag, 4'hb);
        #2;
        rst_n = 0;
        b2.in_valid = 0;
        #1;
        check("ar_valid", b2.out_valid, 0);
        check("ar_state", b2.out_state, 0);
        check("ar_tag", b2.out_tag, 0);
        tick();
        check("ar_held_valid", b2.out_valid, 0);
        #2;
        rst_n = 1;
        b8.in_valid = 1; b8.in_inv = 1; b8.in_tag = 4'h9; b8.in_state = in8;
        tick();
        b8.in_valid = 0;
        check("ar_ready_after", b2.in_ready, 1);
        check("ar_lat1", b8.out_valid, 0);
        tick();
        check("ar_lat2", b8.out_valid, 0);
        check("ar_no_ghost", b2.out_valid, 0);
        tick();
        check("ar_lat3", b8.out_valid, 1);
        check("ar_tag_out", b8.out_tag, 4'h9);
        check("ar_state_out", b8.out_state, ref_shift(in8, 8, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
